uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte producers. Each requester presents bytes on a valid/ready handshake. The arbiter grants one requester at a time, forwards its bytes to the transmitter's `sdata`/`tx_start` inputs, and paces them on `tx_busy`. A grant is held for a burst (up to `req_last` or `MAX_BURST` bytes), so multi-byte messages are not interleaved on the serial line.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: bytes sent per grant before rotation is forced, 1..255.
- `GAP_TIMEOUT`, 255: idle cycles tolerated mid-burst before the grant is dropped, 1..65535.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester byte available.
- `req_data` in 8*N_REQ: requester i's byte is on bits [8i+7:8i].
- `req_last` in N_REQ: the byte is the last of a message; qualified by valid.
- `req_ready` out N_REQ: per-requester accept; combinational from state only.
- `tx_sdata` out 8: byte to the transmitter.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_busy` in 1: transmitter busy flag.
- `grant_id` out $clog2(N_REQ): current or last granted requester.
- `grant_active` out 1: a grant is held.

## Operation
- States:
  - IDLE: no grant held.
  - SEND: grant held, waiting for the granted requester's byte.
  - WAIT: the transmitter is serialising the byte.
- Pointer `rr_ptr` holds the highest-priority index. Priority order is `rr_ptr`, `rr_ptr`+1, … mod N_REQ.
- IDLE:
  - If any `req_valid` bit is set, register the winner into `grant_id`, set `grant_active`=1, clear the byte count and gap counter, and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `req_ready[grant_id]`=1; all other ready bits are 0.
  - On `req_valid[grant_id]`: transfer the byte. Register `tx_sdata`←`req_data[grant_id]`, pulse `tx_start`, latch last=`req_last[grant_id]`, increment the byte count, and go to WAIT.
  - Otherwise increment the gap counter. When it reaches GAP_TIMEOUT, release.
- WAIT:
  - `req_ready` is all 0.
  - `tx_busy` is ignored in the first cycle after `tx_start`, because the transmitter registers busy.
  - From the second cycle on, `tx_busy`=0 ends the byte. Then:
    - If the latched last is set or byte count = MAX_BURST: release.
    - Otherwise clear the gap counter and go to SEND.
- Release:
  - `grant_active`←0, `rr_ptr`←`grant_id`+1 mod N_REQ, go to IDLE.
  - `grant_id` keeps its value.
- Byte count is $clog2(MAX_BURST+1) bits. Gap counter is $clog2(GAP_TIMEOUT+1) bits. Neither counter wraps; both are cleared on every grant.
- Non-granted requesters are never acknowledged; their valid bits may toggle freely.
- A granted requester that drops `req_valid` mid-burst keeps the grant until a transfer or the gap timeout.

## Timing
- Reset state (asynchronous assert, synchronous release): IDLE, `req_ready`=0, `tx_sdata`=8'h00, `tx_start`=0, `grant_id`=0, `grant_active`=0, `rr_ptr`=0, counters 0.
- Reset mid-operation aborts the byte immediately. `tx_start` is never left asserted. The transmitter completes or aborts on its own reset.
- Cycle-level sequence:
  - Valid seen at edge t in IDLE: `grant_active` and `req_ready` are high in cycle t+1.
  - Transfer at edge t+1: `tx_start`=1 and `tx_sdata` are valid in cycle t+2 only.
  - Minimum idle→first `tx_start` latency: 2 cycles.
- Back-to-back bytes within a burst: the next `req_ready` rises the cycle after `tx_busy` is seen low.
- `tx_start` is high for exactly one cycle per accepted byte. `tx_sdata` holds until the next transfer.
- Release → IDLE → re-arbitration costs 1 cycle. The released requester has lowest priority at that arbitration.
- Simultaneous `req_last` and count = MAX_BURST: a single release.

## Test plan
- Single requester (N_REQ=4): req 2 sends 0xA5 with last → one `tx_start` two cycles after valid, `tx_sdata`=0xA5, then `grant_active`=0 and `rr_ptr`=3.
- All four requesters continuously valid, each sending one byte with last → grant order 0,1,2,3,0; exactly one `tx_start` per grant.
- Req 1 sends a 3-byte message 0x11,0x22,0x33 (last on 0x33) while req 0 is valid → bytes appear contiguously on `tx_sdata`, then req 0 is granted.
- MAX_BURST=4, req 3 streams 6 bytes without last while req 0 is valid → after 4 bytes the grant moves to req 0; req 3 resumes on its next turn.
- Req 0 is granted, sends 1 byte without last, then drops valid for GAP_TIMEOUT cycles → `grant_active` falls on cycle GAP_TIMEOUT of the gap with no extra `tx_start`.
- Assert `rstn`=0 in WAIT while `tx_busy`=1 → all outputs are at their reset values asynchronously; after release, the first arbitration starts from req 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// A grant is held for a whole message (req_last) or MAX_BURST bytes, paced on tx_busy.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [7:0]               tx_sdata,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_active
);

    localparam int GW  = $clog2(N_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int GCW = $clog2(GAP_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [BCW-1:0] BC_MAX  = BCW'(MAX_BURST);
    localparam logic [GCW-1:0] GAP_MAX = GCW'(GAP_TIMEOUT);
    localparam logic [GW-1:0]  LAST_ID = GW'(N_REQ - 1);
    localparam logic [GW:0]    N_VAL   = (GW + 1)'(N_REQ);

    logic [1:0]       state;
    logic [GW-1:0]    rr_ptr;
    logic [BCW-1:0]   byte_cnt;
    logic [GCW-1:0]   gap_cnt;
    logic             last_q;

    logic [2*N_REQ-1:0] arb_dbl;
    logic [N_REQ-1:0]   arb_rot;
    logic [GW-1:0]      arb_off;
    logic [GW:0]        arb_sum;
    logic [GW-1:0]      arb_winner;

    function automatic logic [BCW-1:0] bc_inc(input logic [BCW-1:0] v);
        return (v == BC_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [GCW-1:0] gap_inc(input logic [GCW-1:0] v);
        return (v == GAP_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [GW-1:0] next_id(input logic [GW-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // Rotate valids so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        arb_dbl = {req_valid, req_valid} >> rr_ptr;
        arb_rot = arb_dbl[N_REQ-1:0];
        arb_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (arb_rot[k]) arb_off = GW'(k);
        end
        arb_sum = {1'b0, rr_ptr} + {1'b0, arb_off};
        if (arb_sum >= N_VAL) arb_sum = arb_sum - N_VAL;
        arb_winner = arb_sum[GW-1:0];
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_SEND) req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            grant_id     <= '0;
            grant_active <= 1'b0;
            rr_ptr       <= '0;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            last_q       <= 1'b0;
            tx_sdata     <= 8'h00;
            tx_start     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_id     <= arb_winner;
                        grant_active <= 1'b1;
                        byte_cnt     <= '0;
                        gap_cnt      <= '0;
                        state        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (req_valid[grant_id]) begin
                        tx_sdata <= req_data[{grant_id, 3'b000} +: 8];
                        tx_start <= 1'b1;
                        last_q   <= req_last[grant_id];
                        byte_cnt <= bc_inc(byte_cnt);
                        state    <= ST_WAIT;
                    end else begin
                        gap_cnt <= gap_inc(gap_cnt);
                        if (gap_inc(gap_cnt) == GAP_MAX) begin
                            grant_active <= 1'b0;
                            rr_ptr       <= next_id(grant_id);
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    // tx_start is high exactly in the first WAIT cycle, before busy is registered.
                    if (!tx_start && !tx_busy) begin
                        if (last_q || (byte_cnt == BC_MAX)) begin
                            grant_active <= 1'b0;
                            rr_ptr       <= next_id(grant_id);
                            state        <= ST_IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N_REQ=4, MAX_BURST=4, GAP_TIMEOUT=6,
// with a simple transmitter model that stays busy for three cycles per byte.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int GT = 6;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_sdata;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           grant_active;

    int vectors = 0;
    int miscompares = 0;

    int busy_cnt;
    logic [7:0] log_data [64];
    logic [1:0] log_gid  [64];
    int log_n = 0;

    logic [8:0] tmem [N][8];
    int tlen [N];
    int thead [N];

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .GAP_TIMEOUT(GT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_sdata(tx_sdata), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .grant_active(grant_active)
    );

    always #5 clk = ~clk;

    // Transmitter model: registers busy the cycle after tx_start, busy for three cycles.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= 3;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (rstn && tx_start && log_n < 64) begin
            log_data[log_n] = tx_sdata;
            log_gid[log_n]  = grant_id;
            log_n = log_n + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int base, input int idx,
                             input logic [7:0] d, input logic [1:0] g);
        check($sformatf("%s_data%0d", tag, idx), 32'(log_data[base+idx]), 32'(d));
        check($sformatf("%s_gid%0d", tag, idx), 32'(log_gid[base+idx]), 32'(g));
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic load_clear();
        for (int i = 0; i < N; i++) begin
            tlen[i]  = 0;
            thead[i] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        tmem[r][tlen[r]] = {l, d};
        tlen[r]++;
    endtask

    // Present queued bytes on valid/ready until everything is sent and the grant drops.
    task automatic run_traffic(input string tag, input int max_cycles);
        int cyc;
        bit done;
        logic [N-1:0] xfer;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < max_cycles) begin
            for (int i = 0; i < N; i++) begin
                if (thead[i] < tlen[i]) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = tmem[i][thead[i]][7:0];
                    req_last[i]       = tmem[i][thead[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            if (req_valid == '0 && !grant_active) begin
                done = 1'b1;
            end else begin
                xfer = req_ready & req_valid;
                tick();
                cyc++;
                for (int i = 0; i < N; i++) begin
                    if (xfer[i]) thead[i]++;
                end
            end
        end
        check({tag, "_complete"}, 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_start", 32'(tx_start), 32'h0);
        check("rst_sdata", 32'(tx_sdata), 32'h00);
        check("rst_gid", 32'(grant_id), 32'h0);
        check("rst_active", 32'(grant_active), 32'h0);
        check("rst_rrptr", 32'(dut.rr_ptr), 32'h0);
        rstn = 1'b1;
        tick();

        // Single requester, one byte with last
        base = log_n;
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        req_last  = 4'b0100;
        check("t1_idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("t1_active", 32'(grant_active), 32'h1);
        check("t1_ready", 32'(req_ready), 32'h4);
        check("t1_gid", 32'(grant_id), 32'h2);
        check("t1_nostart", 32'(tx_start), 32'h0);
        tick();
        check("t1_start", 32'(tx_start), 32'h1);
        check("t1_sdata", 32'(tx_sdata), 32'hA5);
        check("t1_wait_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        req_last  = '0;
        tick();
        check("t1_start_pulse", 32'(tx_start), 32'h0);
        tick();
        tick();
        tick();
        check("t1_hold", 32'(grant_active), 32'h1);
        tick();
        check("t1_release", 32'(grant_active), 32'h0);
        check("t1_rrptr", 32'(dut.rr_ptr), 32'h3);
        check("t1_gid_kept", 32'(grant_id), 32'h2);
        check("t1_sdata_kept", 32'(tx_sdata), 32'hA5);
        check("t1_count", 32'(log_n - base), 32'd1);

        // All four valid, one byte each, req 0 has a second byte
        do_reset();
        check("t2_rrptr0", 32'(dut.rr_ptr), 32'h0);
        load_clear();
        push(0, 8'h10, 1'b1);
        push(0, 8'h14, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1);
        base = log_n;
        run_traffic("t2", 300);
        check("t2_count", 32'(log_n - base), 32'd5);
        check_log("t2", base, 0, 8'h10, 2'd0);
        check_log("t2", base, 1, 8'h11, 2'd1);
        check_log("t2", base, 2, 8'h12, 2'd2);
        check_log("t2", base, 3, 8'h13, 2'd3);
        check_log("t2", base, 4, 8'h14, 2'd0);

        // Three-byte message from req 1 while req 0 waits
        load_clear();
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        push(0, 8'h0A, 1'b1);
        base = log_n;
        run_traffic("t3", 300);
        check("t3_count", 32'(log_n - base), 32'd4);
        check_log("t3", base, 0, 8'h11, 2'd1);
        check_log("t3", base, 1, 8'h22, 2'd1);
        check_log("t3", base, 2, 8'h33, 2'd1);
        check_log("t3", base, 3, 8'h0A, 2'd0);

        // Burst limit: req 3 streams six bytes without last, req 0 cuts in after four
        load_clear();
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b0);
        push(3, 8'h34, 1'b0);
        push(3, 8'h35, 1'b0);
        push(3, 8'h36, 1'b0);
        push(0, 8'h0B, 1'b1);
        base = log_n;
        run_traffic("t4", 600);
        check("t4_count", 32'(log_n - base), 32'd7);
        check_log("t4", base, 0, 8'h31, 2'd3);
        check_log("t4", base, 1, 8'h32, 2'd3);
        check_log("t4", base, 2, 8'h33, 2'd3);
        check_log("t4", base, 3, 8'h34, 2'd3);
        check_log("t4", base, 4, 8'h0B, 2'd0);
        check_log("t4", base, 5, 8'h35, 2'd3);
        check_log("t4", base, 6, 8'h36, 2'd3);
        check("t4_rrptr", 32'(dut.rr_ptr), 32'h0);

        // Gap timeout after one byte without last
        base = log_n;
        req_valid = 4'b0001;
        req_data[7:0] = 8'h5A;
        req_last  = 4'b0000;
        tick();
        check("t5_ready", 32'(req_ready), 32'h1);
        tick();
        check("t5_start", 32'(tx_start), 32'h1);
        check("t5_sdata", 32'(tx_sdata), 32'h5A);
        req_valid = '0;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("t5_resend_ready", 32'(req_ready), 32'h1);
        check("t5_gap1_active", 32'(grant_active), 32'h1);
        repeat (GT - 1) tick();
        check("t5_gap_last_active", 32'(grant_active), 32'h1);
        check("t5_gap_nostart", 32'(tx_start), 32'h0);
        tick();
        check("t5_timeout", 32'(grant_active), 32'h0);
        check("t5_timeout_ready", 32'(req_ready), 32'h0);
        check("t5_count", 32'(log_n - base), 32'd1);
        check("t5_rrptr", 32'(dut.rr_ptr), 32'h1);

        // Asynchronous reset while the transmitter is busy
        req_valid = 4'b0100;
        req_data[23:16] = 8'h77;
        req_last  = 4'b0100;
        tick();
        check("t6_gid", 32'(grant_id), 32'h2);
        tick();
        check("t6_start", 32'(tx_start), 32'h1);
        req_valid = '0;
        tick();
        check("t6_sdata", 32'(tx_sdata), 32'h77);
        #2;
        rstn = 1'b0;
        req_valid = 4'b1101;
        req_data[7:0] = 8'h0C;
        req_last  = 4'b1101;
        #1;
        check("t6_async_active", 32'(grant_active), 32'h0);
        check("t6_async_start", 32'(tx_start), 32'h0);
        check("t6_async_sdata", 32'(tx_sdata), 32'h00);
        check("t6_async_gid", 32'(grant_id), 32'h0);
        check("t6_async_ready", 32'(req_ready), 32'h0);
        check("t6_async_rrptr", 32'(dut.rr_ptr), 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        check("t6_regrant_active", 32'(grant_active), 32'h1);
        check("t6_regrant_gid", 32'(grant_id), 32'h0);
        check("t6_regrant_ready", 32'(req_ready), 32'h1);
        tick();
        check("t6_regrant_start", 32'(tx_start), 32'h1);
        check("t6_regrant_sdata", 32'(tx_sdata), 32'h0C);
        req_valid = '0;
        req_last  = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
